dm_responder: RTL and testbench

- Data-memory responder: the target end of the pipeline's MEM-stage load/store port.
- Accepts one word request at a time through a valid/ready handshake, inserts a configurable number of wait states, then returns a single-cycle response.
- Replaces the zero-latency combinational data memory so the pipeline can be exercised against slow memory.
- Sits between the EX/MEM register outputs and the MEM/WB register inputs; the CPU's risk unit stalls on req_ready/rsp_valid.

---
 rtl/dm_pkg.sv | 26 ++
 rtl/dm_ram_array.sv | 35 +++
 rtl/dm_responder.sv | 162 ++++++++++++++++
 tb/tb_dm_responder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
//   dm_state_t    : responder FSM states
//   BE_W          : number of byte enables per word
//   MMIO_CYC_ADDR : cycle-counter MMIO address (used only with DM_MMIO_EN)
//   be_mask()     : expands byte enables into a 32-bit bit mask
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dm_state_t;

  localparam int BE_W = 4;
  localparam logic [31:0] MMIO_CYC_ADDR = 32'hFFFF_FFF0;

  function automatic logic [31:0] be_mask(input logic [BE_W-1:0] be);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dm_ram_array.sv
// Word-organised data array: synchronous byte-enabled write, combinational read.
// Ports:
//   clk    : clock
//   we     : write strobe (commit on rising edge)
//   be     : byte enables for the write
//   waddr  : write word index
//   wdata  : write data
//   raddr  : read word index
//   rdata  : combinational read data
module dm_ram_array
  import dm_pkg::*;
#(
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= (mem[waddr] & ~be_mask(be)) | (wdata & be_mask(be));
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: target of the MEM-stage load/store port. Accepts one
// word request via valid/ready, waits WAIT_STATES cycles, then returns a
// single-cycle response.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_wr            : 1 = store, 0 = load
//   req_addr          : byte address
//   req_wdata/req_be  : store data and byte enables
//   rsp_valid         : one-cycle response strobe
//   rsp_rdata         : load data (0 for stores and errors)
//   rsp_err           : misaligned or out-of-range request
// Optional feature macro: DM_MMIO_EN (free-running cycle counter readable at
// MMIO_CYC_ADDR).
module dm_responder
  import dm_pkg::*;
#(
  parameter int    ADDR_W      = 10,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_wr,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err
);

  dm_state_t       state, nextState;
  logic [3:0]      waitCnt;
  logic            wrQ;
  logic [31:0]     addrQ, wdataQ;
  logic [BE_W-1:0] beQ;

  logic            accept, enterResp;
  logic [31:0]     effAddr;
  logic            effWr, effErr, effMmio;
  logic            curErr, curMmio;
  logic [31:0]     rspData, ramRdata;
  logic            ramWe;

  function automatic logic isMmio(input logic [31:0] a);
`ifdef DM_MMIO_EN
    return a == MMIO_CYC_ADDR;
`else
    return a == 32'h0 && a != 32'h0;
`endif
  endfunction

  function automatic logic addrErr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != '0);
  endfunction

`ifdef DM_MMIO_EN
  logic [31:0] cycCnt, cycQ, cycEff;

  always_ff @(posedge clk) begin
    if (rst) cycCnt <= '0;
    else     cycCnt <= cycCnt + 32'd1;
  end
`endif

  always_comb begin
    nextState = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) nextState = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT: if (waitCnt <= 4'd1) nextState = RESP;
      RESP: begin
        rsp_valid = !rst;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign accept    = req_valid && req_ready;
  assign enterResp = (nextState == RESP) && (state != RESP);

  // With zero wait states RESP is entered on the accept edge itself, so the
  // response is formed from the live request rather than the latched copy.
  always_comb begin
    effAddr = (state == IDLE) ? req_addr : addrQ;
    effWr   = (state == IDLE) ? req_wr   : wrQ;
    effMmio = isMmio(effAddr);
    effErr  = addrErr(effAddr) && !effMmio;
    curMmio = isMmio(addrQ);
    curErr  = addrErr(addrQ) && !curMmio;
`ifdef DM_MMIO_EN
    cycEff  = (state == IDLE) ? cycCnt : cycQ;
`endif
    if (effErr || effWr)  rspData = '0;
`ifdef DM_MMIO_EN
    else if (effMmio)     rspData = cycEff;
`endif
    else                  rspData = ramRdata;
  end

  assign ramWe = (state == RESP) && !rst && wrQ && !curErr && !curMmio;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      wrQ       <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
      beQ       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        wrQ     <= req_wr;
        addrQ   <= req_addr;
        wdataQ  <= req_wdata;
        beQ     <= req_be;
        waitCnt <= 4'(WAIT_STATES);
      end else if (state == WAIT) begin
        waitCnt <= waitCnt - 4'd1;
      end
      if (enterResp) begin
        rsp_rdata <= rspData;
        rsp_err   <= effErr;
      end else if (state == RESP) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

`ifdef DM_MMIO_EN
  always_ff @(posedge clk) begin
    if (rst)         cycQ <= '0;
    else if (accept) cycQ <= cycCnt;
  end
`endif

  dm_ram_array #(
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) uRam (
    .clk  (clk),
    .we   (ramWe),
    .be   (beQ),
    .waddr(addrQ[ADDR_W+1:2]),
    .wdata(wdataQ),
    .raddr(effAddr[ADDR_W+1:2]),
    .rdata(ramRdata)
  );

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with two wait states
  logic        v2, wr2, rdy2, rv2, err2;
  logic [31:0] addr2, wd2, rd2;
  logic [3:0]  be2;
  // DUT with zero wait states
  logic        v0, wr0, rdy0, rv0, err0;
  logic [31:0] addr0, wd0, rd0;
  logic [3:0]  be0;

  dm_responder #(.ADDR_W(10), .WAIT_STATES(2), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .req_valid(v2), .req_wr(wr2), .req_addr(addr2),
    .req_wdata(wd2), .req_be(be2), .req_ready(rdy2), .rsp_valid(rv2),
    .rsp_rdata(rd2), .rsp_err(err2));

  dm_responder #(.ADDR_W(10), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_wr(wr0), .req_addr(addr0),
    .req_wdata(wd0), .req_be(be0), .req_ready(rdy0), .rsp_valid(rv0),
    .rsp_rdata(rd0), .rsp_err(err0));

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    int          kind;  // 0 plain, 1 first MMIO load, 2 second MMIO load
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] mmioFirst = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] expData, input logic expErr,
                       input int kind, input bit push, output int accCyc);
    exp_t e;
    bit got;
    got = 0;
    @(posedge clk); #1;
    wr2 = wr; addr2 = addr; wd2 = wdata; be2 = be; v2 = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rdy2) got = 1;
    end
    accCyc = cyc;
    if (!got) begin
      checks++; failures++;
      $display("FAIL issue_timeout: got req_ready=0 expected 1 within 50 cycles");
    end else if (push) begin
      e.data = expData; e.err = expErr; e.cyc = cyc + 3; e.kind = kind;
      q2.push_back(e);
    end
    @(posedge clk); #1;
    v2 = 1'b0;
  endtask

  initial begin
    int acc, acc1;
    v2 = 0; wr2 = 0; addr2 = '0; wd2 = '0; be2 = '0;
    v0 = 0; wr0 = 0; addr0 = '0; wd0 = '0; be0 = '0;
    fork
      begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, rdy2}, 32'd0);
        chk("rst_ready0", {31'b0, rdy0}, 32'd0);
        chk("rst_rspvalid", {31'b0, rv2}, 32'd0);
        chk("rst_rdata", rd2, 32'd0);
        chk("rst_err", {31'b0, err2}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // store then load
        issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, 1, acc);
        issue(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 1, acc);
        // byte-enable merge
        issue(1, 32'h10, 32'h11223344, 4'hF, 32'h0, 0, 0, 1, acc);
        issue(1, 32'h10, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 0, 1, acc);
        issue(0, 32'h10, 32'h0, 4'h0, 32'h11BB33DD, 0, 0, 1, acc);
        // misaligned load
        issue(0, 32'h13, 32'h0, 4'h0, 32'h0, 1, 0, 1, acc);
        // out-of-range store aliases word 0 if it wrongly wrote
        issue(1, 32'h0, 32'h5555AAAA, 4'hF, 32'h0, 0, 0, 1, acc);
        issue(1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0, 1, 0, 1, acc);
        issue(0, 32'h0, 32'h0, 4'h0, 32'h5555AAAA, 0, 0, 1, acc);
        // empty byte-enable store
        issue(1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 0, 1, acc);
        issue(0, 32'h10, 32'h0, 4'h0, 32'h11BB33DD, 0, 0, 1, acc);

        // handshake with zero wait states: accept on even cycles
        @(posedge clk); #1;
        wr0 = 1; addr0 = 32'h40; wd0 = 32'h1; be0 = 4'hF; v0 = 1;
        for (int i = 0; i < 10; i++) begin
          exp_t e;
          @(negedge clk);
          chk("hs_ready", {31'b0, rdy0}, (i % 2 == 0) ? 32'd1 : 32'd0);
          chk("hs_rspvalid", {31'b0, rv0}, (i % 2 == 1) ? 32'd1 : 32'd0);
          if (rdy0) begin
            e.data = 32'h0; e.err = 0; e.cyc = cyc + 1; e.kind = 0;
            q0.push_back(e);
          end
        end
        @(posedge clk); #1 v0 = 0;

        // reset mid-operation abandons the store
        issue(1, 32'h20, 32'h0BADCAFE, 4'hF, 32'h0, 0, 0, 1, acc);
        issue(1, 32'h20, 32'h12345678, 4'hF, 32'h0, 0, 0, 0, acc);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {31'b0, rdy2}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst_ready", {31'b0, rdy2}, 32'd1);
        chk("postrst_rspvalid", {31'b0, rv2}, 32'd0);
        issue(0, 32'h20, 32'h0, 4'h0, 32'h0BADCAFE, 0, 0, 1, acc);

`ifdef DM_MMIO_EN
        issue(0, 32'hFFFF_FFF0, 32'h0, 4'h0, 32'h0, 0, 1, 1, acc1);
        while (cyc < acc1 + 6) @(negedge clk);
        issue(0, 32'hFFFF_FFF0, 32'h0, 4'h0, 32'h0, 0, 2, 1, acc);
        chk("mmio_spacing", acc - acc1, 32'd7);
`else
        issue(0, 32'hFFFF_FFF0, 32'h0, 4'h0, 32'h0, 1, 0, 1, acc1);
`endif

        for (int i = 0; i < 100 && (q2.size() + q0.size()) != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("queue_drained", q2.size() + q0.size(), 32'd0);
      end
      forever begin
        exp_t e;
        @(negedge clk);
        if (rv2) begin
          if (q2.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
          end else begin
            e = q2.pop_front();
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_err", {31'b0, err2}, {31'b0, e.err});
            if (e.kind == 0) chk("rsp_rdata", rd2, e.data);
            else if (e.kind == 1) mmioFirst = rd2;
            else chk("mmio_delta", rd2, mmioFirst + 32'd7);
          end
        end
        if (rv0) begin
          if (q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp0_unexpected: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
          end else begin
            e = q0.pop_front();
            chk("rsp0_cycle", cyc, e.cyc);
            chk("rsp0_err", {31'b0, err0}, {31'b0, e.err});
            chk("rsp0_rdata", rd0, e.data);
          end
        end
      end
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
